// File: rtl/asip_pkg.sv
// asip_pkg: opcode type and constants shared by fetch_stage and control_unit.
package asip_pkg;
    localparam int OPCODE_W = 4;
    typedef logic [OPCODE_W-1:0] opcode_t;
    localparam opcode_t OPC_SUM   = 4'b0000;
    localparam opcode_t OPC_SUMI  = 4'b0010;
    localparam opcode_t OPC_MULFV = 4'b0011;
    localparam opcode_t OPC_CMP   = 4'b0110;
    localparam opcode_t OPC_NOP   = 4'b0111;
    localparam opcode_t OPC_JEQ   = 4'b1001;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: saturating 32-bit counter pair for delivered and flushed instructions.
module fetch_perf_cnt
    import asip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        flush_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            fetch_cnt <= sat_inc(fetch_cnt, fetch_inc);
            flush_cnt <= sat_inc(flush_cnt, flush_inc);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, synchronous imem addressing and IF/ID register of the vector ASIP.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import asip_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_en,
    input  logic               mux_pc,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output opcode_t            opcode,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
);
    logic [ADDR_W-1:0] pc, pc_next;
    logic primed, advance, flush, hold;

    always_comb begin
        flush   = primed & mux_pc;
        hold    = primed & !mux_pc & stall;
        advance = primed & !mux_pc & !stall & pc_en;
        pc_next = flush ? branch_target : advance ? pc + ADDR_W'(1) : pc;
    end

    // Re-presenting pc while not advancing makes the imem re-read the pending word.
    assign imem_addr = pc_next;
    assign opcode = if_id_valid ? opcode_t'(if_id_instr[INSTR_W-1 -: OPCODE_W]) : OPC_NOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            primed      <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else begin
            primed <= 1'b1;
            pc     <= pc_next;
            if (advance) begin
                if_id_pc    <= pc;
                if_id_instr <= imem_rdata;
                if_id_valid <= 1'b1;
            end else if (!hold) begin
                if_id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic flush_inc;
    assign flush_inc = flush & (if_id_valid | (!stall & pc_en));
    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (advance),
        .flush_inc (flush_inc),
        .fetch_cnt (perf_fetch_cnt),
        .flush_cnt (perf_flush_cnt)
    );
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage against a rule-level model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pc_en = 1'b1, mux_pc = 1'b0, stall = 1'b0;
    logic [9:0] branch_target = '0;
    logic [9:0] imem_addr, if_id_pc;
    logic [31:0] imem_rdata, if_id_instr, perf_fetch_cnt, perf_flush_cnt;
    logic if_id_valid;
    logic [3:0] opcode;

    logic [3:0] s_addr, s_if_pc;
    logic [31:0] s_rdata, s_instr, s_fc, s_flc;
    logic s_valid;
    logic [3:0] s_opc;

    logic [31:0] mem [1024];
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .mux_pc(mux_pc), .branch_target(branch_target),
        .stall(stall), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .opcode(opcode),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    fetch_stage #(.ADDR_W(4)) u_small (
        .clk(clk), .rst(rst), .pc_en(1'b1), .mux_pc(1'b0), .branch_target(4'h0),
        .stall(1'b0), .imem_addr(s_addr), .imem_rdata(s_rdata), .if_id_valid(s_valid),
        .if_id_pc(s_if_pc), .if_id_instr(s_instr), .opcode(s_opc),
        .perf_fetch_cnt(s_fc), .perf_flush_cnt(s_flc)
    );

    always @(posedge clk) imem_rdata <= mem[imem_addr];
    always @(posedge clk) s_rdata <= {s_addr, 28'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic        v;
        int          pc;
        logic [31:0] instr;
        longint      fc;
        longint      flc;
    } exp_t;
    exp_t q[$];

    // Reference model: architectural state advanced by the priority rules at each edge.
    int m_pc = 0, m_ifpc = 0;
    bit m_primed = 0, m_valid = 0;
    logic [31:0] m_instr = '0;
    longint m_fc = 0, m_flc = 0;

    function automatic exp_t snap();
        exp_t e;
        e.v = m_valid; e.pc = m_ifpc; e.instr = m_instr;
`ifdef FETCH_PERF_CNT_EN
        e.fc = m_fc; e.flc = m_flc;
`else
        e.fc = 0; e.flc = 0;
`endif
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_ifpc = 0; m_primed = 0; m_valid = 0; m_instr = '0; m_fc = 0; m_flc = 0;
            q.delete();
        end else if (!m_primed) begin
            m_primed = 1; m_valid = 0;
        end else if (mux_pc) begin
            if (m_valid || (!stall && pc_en)) m_flc++;
            m_pc = int'(branch_target); m_valid = 0;
        end else if (stall) begin
        end else if (!pc_en) begin
            m_valid = 0;
        end else begin
            m_ifpc = m_pc; m_instr = mem[m_pc]; m_valid = 1;
            m_pc = (m_pc + 1) % 1024; m_fc++;
        end
        q.push_back(snap());
    end

    int s_exp = 0;
    always @(posedge rst) s_exp = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int ea;
            e = q.pop_front();
            ea = !m_primed ? m_pc : mux_pc ? int'(branch_target) : (stall || !pc_en) ? m_pc : (m_pc + 1) % 1024;
            chk("valid", 64'(if_id_valid), 64'(e.v));
            chk("opcode", 64'(opcode), e.v ? 64'(e.instr[31:28]) : 64'h7);
            chk("imem_addr", 64'(imem_addr), 64'(ea));
            if (e.v || rst) begin
                chk("if_id_pc", 64'(if_id_pc), 64'(e.pc));
                chk("if_id_instr", 64'(if_id_instr), 64'(e.instr));
            end
            chk("fetch_cnt", 64'(perf_fetch_cnt), 64'(e.fc));
            chk("flush_cnt", 64'(perf_flush_cnt), 64'(e.flc));
        end
        if (s_valid) begin
            chk("wrap_pc", 64'(s_if_pc), 64'(s_exp));
            s_exp = (s_exp + 1) % 16;
        end
    end

    task automatic step(input logic m, input logic [9:0] t, input logic s, input logic e);
        mux_pc = m; branch_target = t; stall = s; pc_en = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = {k[3:0], 28'($urandom)};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (11) step(0, 0, 0, 1);
        step(1, 10'h20, 0, 1);
        step(1, 10'h40, 0, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_10", 64'(perf_fetch_cnt), 64'd10);
        chk("perf_flush_2", 64'(perf_flush_cnt), 64'd2);
`else
        chk("perf_fetch_0", 64'(perf_fetch_cnt), 64'd0);
        chk("perf_flush_0", 64'(perf_flush_cnt), 64'd0);
`endif
        step(1, 10'h4, 0, 1);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 1);
        step(1, 10'h20, 0, 1);
        repeat (2) step(0, 0, 0, 1);
        step(1, 10'h30, 1, 1);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 10'h8, 0, 1);
        step(0, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(if_id_valid), 64'd0);
        chk("async_rst_pc", 64'(if_id_pc), 64'd0);
        chk("async_rst_instr", 64'(if_id_instr), 64'd0);
        chk("async_rst_opcode", 64'(opcode), 64'h7);
        chk("async_rst_addr", 64'(imem_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) < 10, 10'($urandom), $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) >= 15);
        repeat (2) step(0, 0, 0, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
